// File: rtl/turbo_pkg.sv
// Shared definitions for the turbo encoder arbiter and the encoder control FSM.
// Frame-length defaults and the counter width live here so both sides agree.
package turbo_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    STREAM = 3'd2,
    TAIL   = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int K_SHORT_DEF     = 4;
  localparam int K_LONG_DEF      = 6;
  localparam int TAIL_CYCLES_DEF = 4;
  localparam int CNT_W           = 14;

  function automatic logic [1:0] onehot2(input logic sel);
    return sel ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker: a lone request wins outright,
// a contended request goes to the source that did not own the encoder last.
module rr_pick2
  import turbo_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       winner,
  output logic       valid
);

  assign valid  = |req;
  assign winner = (req == 2'b11) ? ~last_owner : req[1];

endmodule

// File: rtl/turbo_encoder_arbiter.sv
// Shares one turbo encoder between two frame sources, one frame per grant,
// holding the grant from the start pulse through trellis termination.
//
// state  | meaning
// IDLE   | waiting for a request; winner, length flag latched on exit
// START  | one-cycle encoder start pulse with latched length flag
// STREAM | owner's bits routed into the encoder, K cycles
// TAIL   | grant held while encoder terminates trellis, TAIL_CYCLES cycles
// DONE   | done pulse to owner, round-robin pointer updated
module turbo_encoder_arbiter
  import turbo_pkg::*;
#(
  parameter int K_SHORT     = K_SHORT_DEF,
  parameter int K_LONG      = K_LONG_DEF,
  parameter int TAIL_CYCLES = TAIL_CYCLES_DEF,
  parameter int CNT_W       = turbo_pkg::CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [1:0] len_flag_in,
  input  logic [1:0] data_in,
  output logic [1:0] grant,
  output logic [1:0] data_ready,
  output logic [1:0] done,
  output logic       enc_start,
  output logic       enc_length_flag,
  output logic       enc_data,
  output logic       busy
);

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             len_q, len_d;
  logic             last_owner_q, last_owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] k_last;
  logic [CNT_W-1:0] tail_last;
  logic             pick_winner;
  logic             pick_valid;
  logic [1:0]       owner_oh;

  rr_pick2 u_pick (
    .req        (req),
    .last_owner (last_owner_q),
    .winner     (pick_winner),
    .valid      (pick_valid)
  );

  assign k_last    = len_q ? CNT_W'(K_LONG - 1) : CNT_W'(K_SHORT - 1);
  assign tail_last = CNT_W'(TAIL_CYCLES - 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      len_q        <= 1'b0;
      last_owner_q <= 1'b1;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      len_q        <= len_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    len_d        = len_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d = pick_winner;
          len_d   = len_flag_in[pick_winner];
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = STREAM;
      end
      STREAM: begin
        if (cnt_q == k_last) begin
          cnt_d   = '0;
          state_d = TAIL;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      TAIL: begin
        if (cnt_q == tail_last) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        last_owner_d = owner_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend on registered state only; enc_data is the one pass-through.
  assign owner_oh        = onehot2(owner_q);
  assign busy            = (state_q != IDLE);
  assign grant           = (state_q == START || state_q == STREAM || state_q == TAIL) ? owner_oh : 2'b00;
  assign data_ready      = (state_q == STREAM) ? owner_oh : 2'b00;
  assign done            = (state_q == DONE) ? owner_oh : 2'b00;
  assign enc_start       = (state_q == START);
  assign enc_length_flag = busy & len_q;
  assign enc_data        = (state_q == STREAM) ? data_in[owner_q] : 1'b0;

endmodule

// File: tb/tb_turbo_encoder_arbiter.sv
// Directed bench for turbo_encoder_arbiter: per-cycle expected outputs are
// written from the frame timing (START at t+1, K data cycles, 4 tail cycles, DONE).
module tb_turbo_encoder_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req;
  logic [1:0] len_flag_in;
  logic [1:0] data_in;
  logic [1:0] grant;
  logic [1:0] data_ready;
  logic [1:0] done;
  logic       enc_start;
  logic       enc_length_flag;
  logic       enc_data;
  logic       busy;

  int errors = 0;
  int checks = 0;
  logic [9:0] got, exp;

  turbo_encoder_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .req             (req),
    .len_flag_in     (len_flag_in),
    .data_in         (data_in),
    .grant           (grant),
    .data_ready      (data_ready),
    .done            (done),
    .enc_start       (enc_start),
    .enc_length_flag (enc_length_flag),
    .enc_data        (enc_data),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  // Output vector layout: grant, data_ready, done, enc_start, enc_length_flag, enc_data, busy
  always_comb got = {grant, data_ready, done, enc_start, enc_length_flag, enc_data, busy};

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 2'b00; len_flag_in = 2'b00; data_in = 2'b00;
    adv(); adv();
    #1;
    checks++;
    if (got !== 10'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b expected=%b", got, 10'b0);
    end
    reset = 1'b0;
    adv();
  endtask

  task automatic test_short_frame();
    logic [3:0] sb;
    logic       b;
    sb = 4'b1101;
    adv();
    req = 2'b01; len_flag_in = 2'b00; data_in = 2'b00;
    for (int k = 1; k <= 11; k++) begin
      adv();
      b = (k >= 2 && k <= 5) ? sb[k-2] : 1'b0;
      data_in = (k >= 2 && k <= 5) ? {1'b1, b} : 2'b11;
      #1;
      exp = {(k >= 1 && k <= 9) ? 2'b01 : 2'b00,
             (k >= 2 && k <= 5) ? 2'b01 : 2'b00,
             (k == 10) ? 2'b01 : 2'b00,
             (k == 1), 1'b0, b, (k <= 10)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL short_frame k=%0d got=%b expected=%b", k, got, exp);
      end
      if (k == 10) req = 2'b00;
    end
  endtask

  task automatic test_long_frame();
    logic b;
    int   rc;
    rc = 0;
    adv();
    req = 2'b10; len_flag_in = 2'b10; data_in = 2'b01;
    for (int k = 1; k <= 13; k++) begin
      adv();
      b = k[0];
      data_in = {b, 1'b1};
      #1;
      if (data_ready[1]) rc++;
      exp = {(k >= 1 && k <= 11) ? 2'b10 : 2'b00,
             (k >= 2 && k <= 7) ? 2'b10 : 2'b00,
             (k == 12) ? 2'b10 : 2'b00,
             (k == 1), (k <= 12), (k >= 2 && k <= 7) ? b : 1'b0, (k <= 12)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL long_frame k=%0d got=%b expected=%b", k, got, exp);
      end
      if (k == 12) req = 2'b00;
    end
    checks++;
    if (rc !== 6) begin
      errors++;
      $display("FAIL long_ready_cycles got=%0d expected=6", rc);
    end
  endtask

  task automatic test_ignore_changes();
    logic b;
    adv();
    req = 2'b01; len_flag_in = 2'b00; data_in = 2'b00;
    for (int k = 1; k <= 11; k++) begin
      adv();
      b = k[1];
      if (k >= 2 && k <= 9) begin
        req = 2'b11; len_flag_in = 2'b11;
      end
      data_in = {1'b1, b};
      #1;
      exp = {(k >= 1 && k <= 9) ? 2'b01 : 2'b00,
             (k >= 2 && k <= 5) ? 2'b01 : 2'b00,
             (k == 10) ? 2'b01 : 2'b00,
             (k == 1), 1'b0, (k >= 2 && k <= 5) ? b : 1'b0, (k <= 10)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL ignore_changes k=%0d got=%b expected=%b", k, got, exp);
      end
      if (k == 10) begin
        req = 2'b00; len_flag_in = 2'b00;
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic saw_done1;
    logic finished;
    saw_done1 = 1'b0;
    finished  = 1'b0;
    adv();
    req = 2'b10; len_flag_in = 2'b10; data_in = 2'b11;
    adv();
    #1;
    checks++;
    if ({grant, enc_start, enc_length_flag} !== 4'b1011) begin
      errors++;
      $display("FAIL rst_mid_start got=%b expected=1011", {grant, enc_start, enc_length_flag});
    end
    adv(); adv();
    reset = 1'b1;
    adv();
    #1;
    checks++;
    if (got !== 10'b0) begin
      errors++;
      $display("FAIL rst_mid_outputs got=%b expected=%b", got, 10'b0);
    end
    reset = 1'b0; req = 2'b11; len_flag_in = 2'b00;
    adv();
    #1;
    checks++;
    if ({grant, enc_start} !== 3'b011) begin
      errors++;
      $display("FAIL rst_mid_regrant got=%b expected=011", {grant, enc_start});
    end
    req = 2'b00;
    for (int k = 0; k < 20 && !finished; k++) begin
      adv();
      #1;
      if (done[1]) saw_done1 = 1'b1;
      if (!busy) finished = 1'b1;
    end
    checks++;
    if (finished !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_timeout busy=%b expected idle within 20 cycles", busy);
    end
    checks++;
    if (saw_done1 !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_no_done done1_seen=%b expected=0", saw_done1);
    end
  endtask

  task automatic test_contention();
    logic [3:0] ord;
    logic       two_hot;
    int         n;
    ord = 4'b0000; two_hot = 1'b0; n = 0;
    reset = 1'b1; req = 2'b11; len_flag_in = 2'b00; data_in = 2'b00;
    adv(); adv();
    reset = 1'b0;
    for (int k = 0; k < 80 && !(n == 4 && !busy); k++) begin
      adv();
      #1;
      if (grant == 2'b11) two_hot = 1'b1;
      if (enc_start && n < 4) begin
        ord[n] = grant[1];
        n++;
        if (n == 4) req = 2'b00;
      end
    end
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL contention_frames got=%0d expected=4", n);
    end
    checks++;
    if (ord !== 4'b1010) begin
      errors++;
      $display("FAIL contention_order got=%b expected=1010 (bit i = owner of frame i)", ord);
    end
    checks++;
    if (two_hot !== 1'b0) begin
      errors++;
      $display("FAIL contention_two_hot got=%b expected=0", two_hot);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL contention_idle busy=%b expected=0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_short_frame();
    test_long_frame();
    test_ignore_changes();
    test_reset_mid_frame();
    test_contention();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
